fft_bfly_ctrl: RTL

FFT_BFLY_CTRL -- requirements
Module: fft_bfly_ctrl

---
 rtl/fft_bfly_ctrl_if.sv | 27 ++
 rtl/fft_bfly_ctrl.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/fft_bfly_ctrl_if.sv
// Handshake and RAM/ROM addressing bundle between the DIF FFT sequencer and its datapath.
// master: the sequencer side; slave: butterfly/RAM/host side.
interface fft_bfly_ctrl_if #(
  parameter int unsigned Log2N = 3
);
  logic             Start;
  logic             Done;
  logic             Busy;
  logic             Bfly_Start;
  logic             Bfly_Done;
  logic             Mem_Rd_En;
  logic             Mem_Wr_En;
  logic [Log2N-1:0] Mem_Addr0;
  logic [Log2N-1:0] Mem_Addr1;
  logic [Log2N-2:0] Tw_Addr;
  logic             Error;

  modport master (
    input  Start, Bfly_Done,
    output Done, Busy, Bfly_Start, Mem_Rd_En, Mem_Wr_En, Mem_Addr0, Mem_Addr1, Tw_Addr, Error
  );

  modport slave (
    output Start, Bfly_Done,
    input  Done, Busy, Bfly_Start, Mem_Rd_En, Mem_Wr_En, Mem_Addr0, Mem_Addr1, Tw_Addr, Error
  );
endinterface

// File: rtl/fft_bfly_ctrl.sv
// In-place radix-2 DIF FFT sequencer: walks stages/butterflies, strobes RAM and butterfly.
// Optional WAIT watchdog enabled by defining FFT_BFLY_CTRL_WATCHDOG_EN.
module fft_bfly_ctrl #(
  parameter int unsigned DataWidth = 16,
  parameter int unsigned Log2N     = 3
) (
  input logic            clk,
  input logic            reset,
  fft_bfly_ctrl_if.master bus
);

  localparam int unsigned N    = 1 << Log2N;
  localparam int unsigned Half = N / 2;
  localparam int unsigned BW   = Log2N - 1;
  localparam logic [BW-1:0] BLast = BW'(Half - 1);
  localparam logic [3:0]    SLast = 4'(Log2N - 1);

  if (Log2N < 2 || Log2N > 10 || DataWidth == 0) begin : g_bad_param
    $error("fft_bfly_ctrl: Log2N must be 2..10 and DataWidth nonzero");
  end

  typedef enum logic [2:0] {StIdle, StRead, StLaunch, StWait, StWrite, StFinish} state_e;

  state_e           state_q, state_d;
  logic [3:0]       s_q, s_d;
  logic [BW-1:0]    b_q, b_d;
  logic [Log2N-1:0] a0_q, a0_d, a1_q, a1_d;
  logic [BW-1:0]    tw_q, tw_d;
  logic             rd_q, rd_d, ls_q, ls_d, wr_q, wr_d, done_q, done_d, busy_q, busy_d;

`ifdef FFT_BFLY_CTRL_WATCHDOG_EN
  localparam logic [3:0] WdLast = 4'd15;
  logic [3:0] wd_q, wd_d;
  logic       err_q, err_d;
`endif

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    b_d     = b_q;
`ifdef FFT_BFLY_CTRL_WATCHDOG_EN
    wd_d    = wd_q;
    err_d   = err_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus.Start) begin
          s_d     = '0;
          b_d     = '0;
          state_d = StRead;
`ifdef FFT_BFLY_CTRL_WATCHDOG_EN
          err_d   = 1'b0;
`endif
        end
      end
      StRead:   state_d = StLaunch;
      StLaunch: begin
        state_d = StWait;
`ifdef FFT_BFLY_CTRL_WATCHDOG_EN
        wd_d    = '0;
`endif
      end
      StWait: begin
        if (bus.Bfly_Done) begin
          state_d = StWrite;
`ifdef FFT_BFLY_CTRL_WATCHDOG_EN
        end else if (wd_q == WdLast) begin
          // Butterfly hung: abandon the pass without writing back.
          state_d = StIdle;
          err_d   = 1'b1;
        end else begin
          wd_d    = wd_q + 4'd1;
`endif
        end
      end
      StWrite: begin
        if (b_q == BLast) begin
          b_d = '0;
          if (s_q == SLast) begin
            state_d = StFinish;
          end else begin
            s_d     = s_q + 4'd1;
            state_d = StRead;
          end
        end else begin
          b_d     = b_q + BW'(1);
          state_d = StRead;
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Pair addresses: insert a zero bit into b at position Log2N-1-s; partner sets that bit.
  int unsigned si, span, grp, k, lo;
  always_comb begin
    si   = 32'(s_d);
    span = N >> (si + 1);
    grp  = 32'(b_d) >> (Log2N - 1 - si);
    k    = 32'(b_d) & (span - 1);
    lo   = (grp << (Log2N - si)) | k;
    a0_d = a0_q;
    a1_d = a1_q;
    tw_d = tw_q;
    if (state_d == StRead) begin
      a0_d = Log2N'(lo);
      a1_d = Log2N'(lo + span);
      tw_d = BW'(k << si);
    end
    rd_d   = (state_d == StRead);
    ls_d   = (state_d == StLaunch);
    wr_d   = (state_d == StWrite);
    done_d = (state_d == StFinish);
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      s_q     <= '0;
      b_q     <= '0;
      a0_q    <= '0;
      a1_q    <= '0;
      tw_q    <= '0;
      rd_q    <= 1'b0;
      ls_q    <= 1'b0;
      wr_q    <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef FFT_BFLY_CTRL_WATCHDOG_EN
      wd_q    <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      b_q     <= b_d;
      a0_q    <= a0_d;
      a1_q    <= a1_d;
      tw_q    <= tw_d;
      rd_q    <= rd_d;
      ls_q    <= ls_d;
      wr_q    <= wr_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
`ifdef FFT_BFLY_CTRL_WATCHDOG_EN
      wd_q    <= wd_d;
      err_q   <= err_d;
`endif
    end
  end

  assign bus.Mem_Addr0  = a0_q;
  assign bus.Mem_Addr1  = a1_q;
  assign bus.Tw_Addr    = tw_q;
  assign bus.Mem_Rd_En  = rd_q;
  assign bus.Bfly_Start = ls_q;
  assign bus.Mem_Wr_En  = wr_q;
  assign bus.Done       = done_q;
  assign bus.Busy       = busy_q;
`ifdef FFT_BFLY_CTRL_WATCHDOG_EN
  assign bus.Error      = err_q;
`else
  assign bus.Error      = 1'b0;
`endif

endmodule
